// File: rtl/tradeoff_8bits_search.sv
// Cost-budget search core: finds the largest N with COST_A*N^2 + COST_C <= W and raises found.
// Define TRADEOFF_BINARY_SEARCH_EN for a 9-step binary search instead of the linear scan.
module tradeoff_8bits_search #(
    parameter int W_BITS = 20,
    parameter int N_BITS = 9,
    parameter int COST_A = 7,
    parameter int COST_C = 39000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W_BITS-1:0] W,
    output logic [N_BITS-1:0] N,
    output logic              found
);
    localparam int CW = W_BITS + 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [W_BITS-1:0] w_reg_q, w_reg_d;
    logic [N_BITS-1:0] n_q, n_d;
    logic [CW-1:0]     cost_q, cost_d;
    logic              found_q, found_d;
    logic [CW-1:0]     w_ext;

    assign w_ext = CW'(w_reg_q);

`ifdef TRADEOFF_BINARY_SEARCH_EN
    localparam int BW = $clog2(N_BITS);
    logic [BW-1:0]     bit_q, bit_d;
    logic [N_BITS-1:0] trial;
    logic [CW-1:0]     trial_cost;

    assign trial      = n_q | (N_BITS'(1) << bit_q);
    assign trial_cost = CW'(COST_A) * CW'(trial) * CW'(trial) + CW'(COST_C);
`else
    logic [CW-1:0] cost_next;
    logic          n_max;

    // cost(n+1) - cost(n) = COST_A*(2n+1); constant coefficient, so shift-add only.
    assign cost_next = cost_q + CW'(COST_A) * CW'({n_q, 1'b1});
    assign n_max     = &n_q;
`endif

    always_comb begin
        state_d = state_q;
        w_reg_d = w_reg_q;
        n_d     = n_q;
        cost_d  = cost_q;
        found_d = found_q;
`ifdef TRADEOFF_BINARY_SEARCH_EN
        bit_d   = bit_q;
`endif
        case (state_q)
            IDLE: begin
                w_reg_d = W;
                n_d     = '0;
                cost_d  = CW'(COST_C);
                found_d = 1'b0;
                state_d = SEARCH;
`ifdef TRADEOFF_BINARY_SEARCH_EN
                bit_d   = BW'(N_BITS - 1);
`endif
            end
            SEARCH: begin
`ifdef TRADEOFF_BINARY_SEARCH_EN
                if (trial_cost <= w_ext) begin
                    n_d    = trial;
                    cost_d = trial_cost;
                end
                if (bit_q == '0) begin
                    state_d = DONE;
                    found_d = 1'b1;
                end else begin
                    bit_d = bit_q - 1'b1;
                end
`else
                if (cost_next <= w_ext && !n_max) begin
                    n_d    = n_q + 1'b1;
                    cost_d = cost_next;
                end else begin
                    state_d = DONE;
                    found_d = 1'b1;
                end
`endif
            end
            DONE: begin
            end
            default: state_d = IDLE;
        endcase

        // A budget change outside IDLE overrides any search step on the same edge.
        if (state_q != IDLE && W != w_reg_q) begin
            w_reg_d = W;
            n_d     = '0;
            cost_d  = CW'(COST_C);
            found_d = 1'b0;
            state_d = SEARCH;
`ifdef TRADEOFF_BINARY_SEARCH_EN
            bit_d   = BW'(N_BITS - 1);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            w_reg_q <= '0;
            n_q     <= '0;
            cost_q  <= CW'(COST_C);
            found_q <= 1'b0;
`ifdef TRADEOFF_BINARY_SEARCH_EN
            bit_q   <= BW'(N_BITS - 1);
`endif
        end else begin
            state_q <= state_d;
            w_reg_q <= w_reg_d;
            n_q     <= n_d;
            cost_q  <= cost_d;
            found_q <= found_d;
`ifdef TRADEOFF_BINARY_SEARCH_EN
            bit_q   <= bit_d;
`endif
        end
    end

    assign N     = n_q;
    assign found = found_q;

endmodule

// File: tb/tb_tradeoff_8bits_search.sv
// Bench for tradeoff_8bits_search: directed and random budgets against a brute-force reference.
module tb_tradeoff_8bits_search;
    logic        clk;
    logic        rst_n;
    logic [19:0] w;
    logic [8:0]  n;
    logic        found;

    int tests = 0;
    int fails = 0;

`ifdef TRADEOFF_BINARY_SEARCH_EN
    localparam bit BINARY = 1'b1;
`else
    localparam bit BINARY = 1'b0;
`endif

    tradeoff_8bits_search dut (
        .clk   (clk),
        .rst_n (rst_n),
        .W     (w),
        .N     (n),
        .found (found)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Largest n in [0,511] with 7n^2 + 39000 <= budget, by exhaustive scan.
    function automatic int ref_n(input int budget);
        int best = 0;
        for (int k = 0; k <= 511; k++) begin
            longint c = 64'd7 * k * k + 64'd39000;
            if (c <= budget) best = k;
        end
        return best;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Assumes the next rising edge is the capture/restart edge E0.
    task automatic wait_found(input string tag, input int exp_n);
        int k;
        int lat;
        lat = BINARY ? 9 : exp_n + 1;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_drop"}, {31'd0, found}, 32'd0);
        k = 0;
        while (found !== 1'b1 && k < 600) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        check({tag, "_found"}, {31'd0, found}, 32'd1);
        check({tag, "_latency"}, k, lat);
        check({tag, "_n"}, {23'd0, n}, exp_n);
    endtask

    task automatic apply_w(input string tag, input logic [19:0] val);
        @(negedge clk);
        w = val;
        wait_found(tag, ref_n(int'(val)));
    endtask

    logic [19:0] seq_w [9] = '{20'd494444, 20'd494447, 20'd494443, 20'd494449, 20'd494441,
                               20'd494453, 20'd494437, 20'd494461, 20'd494429};

    initial begin
        int bad;
        int cyc;
        logic [19:0] rv;
        logic [8:0]  held_n;

        rst_n = 1'b0;
        w     = 20'd0;
        #12;
        check("reset_found", {31'd0, found}, 32'd0);
        check("reset_n", {23'd0, n}, 32'd0);

        w = 20'd494446;
        @(negedge clk);
        rst_n = 1'b1;
        wait_found("nominal", 255);

        for (int i = 0; i < 9; i++) apply_w($sformatf("seq%0d", i), seq_w[i]);

        apply_w("w_zero", 20'd0);
        apply_w("w_39006", 20'd39006);
        apply_w("w_39007", 20'd39007);
        apply_w("w_max", 20'hFFFFF);
        check("ref_max", ref_n(1048575), 379);

        // Abort: start a long search, change budget partway through.
        cyc = BINARY ? 4 : 50;
        @(negedge clk);
        w = 20'd494446;
        bad = 0;
        for (int i = 0; i < cyc; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (found !== 1'b0) bad++;
        end
        check("abort_no_pulse", bad, 0);
        w = 20'd39007;
        wait_found("abort", 1);

        // Reset in the middle of a search.
        @(negedge clk);
        w = 20'd494446;
        for (int i = 0; i < cyc; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_found", {31'd0, found}, 32'd0);
        check("midrst_n", {23'd0, n}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_found("after_rst", 255);

        // Stability with constant budget.
        held_n = n;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (found !== 1'b1 || n !== held_n) bad++;
        end
        check("hold_stable", bad, 0);

        // Random budgets, full range and near the offset.
        for (int i = 0; i < 16; i++) begin
            do begin
                if (i % 2 == 0) rv = 20'($urandom_range(0, 1048575));
                else            rv = 20'($urandom_range(38000, 60000));
            end while (rv == w);
            apply_w($sformatf("rand%0d", i), rv);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "watchdog");
    end
endmodule
